led_controller: RTL and testbench

LED_CONTROLLER -- requirements
Module: led_controller

---
 rtl/led_controller_if.sv | 34 +++
 rtl/led_controller.sv | 148 ++++++++++++++
 tb/tb_led_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/led_controller_if.sv
// Bundle that carries the LED controller's start request, memory read port and status.
// The slave view belongs to the controller; the master view belongs to its environment.
interface led_controller_if #(
    parameter int LED_COUNT  = 16,
    parameter int ADDR_WIDTH = 13
);
    logic                  copy_start;
    logic [ADDR_WIDTH-1:0] mem_din_addr;
    logic                  mem_din_re;
    logic [15:0]           mem_din;
    logic [LED_COUNT-1:0]  leds_out;
    logic                  busy;
    logic                  copy_done;

    modport master (
        output copy_start,
        output mem_din,
        input  mem_din_addr,
        input  mem_din_re,
        input  leds_out,
        input  busy,
        input  copy_done
    );

    modport slave (
        input  copy_start,
        input  mem_din,
        output mem_din_addr,
        output mem_din_re,
        output leds_out,
        output busy,
        output copy_done
    );
endinterface

// File: rtl/led_controller.sv
// Reads LED_COUNT words from data memory and drives one LED per word (on iff word nonzero).
// Define LED_ATOMIC_UPDATE_EN to present a whole pass at once via a shadow register.
module led_controller #(
    parameter int LED_COUNT  = 16,
    parameter int LED_ADDR   = 7808,
    parameter int ADDR_WIDTH = 13
) (
    input  logic              clk,
    input  logic              reset,
    led_controller_if.slave   bus
);
    localparam int                    IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(LED_ADDR);
    localparam logic [IDX_W-1:0]      LAST  = IDX_W'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  r_re;
    logic                  w_re_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_done;
    logic                  w_done_next;

    // Word index presented last cycle; its data is on mem_din now.
    logic                  r_cap_valid;
    logic [IDX_W-1:0]      r_cap_idx;

    logic [LED_COUNT-1:0]  r_leds;
    logic [LED_COUNT-1:0]  w_base;
    logic [LED_COUNT-1:0]  w_merged;
    logic                  w_word_nz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_addr      <= BASE;
            r_re        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_addr      <= w_addr_next;
            r_re        <= w_re_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_cap_valid <= (r_state == READ);
            r_cap_idx   <= r_idx;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_addr_next  = BASE;
        w_re_next    = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.copy_start) begin
                    w_state_next = READ;
                    w_idx_next   = '0;
                    w_re_next    = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end
            READ: begin
                w_busy_next = 1'b1;
                if (r_idx == LAST) begin
                    w_state_next = DRAIN;
                end else begin
                    w_idx_next  = r_idx + IDX_W'(1);
                    w_addr_next = r_addr + ADDR_WIDTH'(1);
                    w_re_next   = 1'b1;
                end
            end
            DRAIN: begin
                w_state_next = IDLE;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_word_nz = |bus.mem_din;

    // Word i lands on bit LED_COUNT-1-i, so LED 0's word drives the MSB.
    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_bit
        localparam logic [IDX_W-1:0] SLOT = IDX_W'(LED_COUNT - 1 - gi);
        assign w_merged[gi] = (r_cap_valid && (r_cap_idx == SLOT)) ? w_word_nz : w_base[gi];
    end

`ifdef LED_ATOMIC_UPDATE_EN
    logic [LED_COUNT-1:0] r_shadow;

    assign w_base = r_shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (r_cap_valid) begin
            r_shadow <= w_merged;
        end
    end

    // Last word is captured on the DRAIN edge, so load the merged value directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else if (r_state == DRAIN) begin
            r_leds <= w_merged;
        end
    end
`else
    assign w_base = r_leds;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_leds <= '0;
        end else if (r_cap_valid) begin
            r_leds <= w_merged;
        end
    end
`endif

    assign bus.mem_din_addr = r_addr;
    assign bus.mem_din_re   = r_re;
    assign bus.leds_out     = r_leds;
    assign bus.busy         = r_busy;
    assign bus.copy_done    = r_done;
endmodule

// File: tb/tb_led_controller.sv
// Scoreboard bench for led_controller: stimulus queues expected LED images, a monitor checks them at copy_done.
module tb_led_controller;
    localparam int LED_COUNT  = 16;
    localparam int LED_ADDR   = 7808;
    localparam int ADDR_WIDTH = 13;

    typedef struct {
        logic [15:0] leds;
        int          gap;
    } exp_t;

    logic clk;
    logic reset;
    logic [15:0] mem [LED_COUNT];
    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks;
    int n_pass;
    int cyc;
    int last_done_cyc;
    int busy_run;
    int proto_err;
    logic prev_done;

    led_controller_if #(.LED_COUNT(LED_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    led_controller #(
        .LED_COUNT (LED_COUNT),
        .LED_ADDR  (LED_ADDR),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Synchronous memory model: one cycle read latency, junk when not reading.
    always @(posedge clk) begin
        int idx;
        idx = int'(bus.mem_din_addr) - LED_ADDR;
        if (bus.mem_din_re && idx >= 0 && idx < LED_COUNT) bus.mem_din <= mem[idx];
        else bus.mem_din <= 16'hFFFF;
    end

    // Monitor: bus protocol tracking and scoreboard pop on every copy_done.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            busy_run  = 0;
            proto_err = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy) begin
                if (bus.mem_din_re) begin
                    if (bus.mem_din_addr !== ADDR_WIDTH'(LED_ADDR + busy_run)) proto_err++;
                end else if (busy_run != LED_COUNT || bus.mem_din_addr !== ADDR_WIDTH'(LED_ADDR)) begin
                    proto_err++;
                end
                busy_run++;
            end else if (bus.mem_din_re !== 1'b0 || bus.mem_din_addr !== ADDR_WIDTH'(LED_ADDR)) begin
                proto_err++;
            end
            if (bus.copy_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_copy_done: got pulse at cycle %0d required none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("leds_at_done", 32'(bus.leds_out), 32'(mon_e.leds));
                    check("busy_cycles", busy_run, LED_COUNT + 1);
                    check("bus_protocol_errs", proto_err, 0);
                    check("done_width", 32'(prev_done), 0);
                    if (mon_e.gap != 0) check("done_spacing", cyc - last_done_cyc, mon_e.gap);
                    $display("pass done: cycle %0d leds %h expected %h busy_cycles %0d",
                             cyc, bus.leds_out, mon_e.leds, busy_run);
                end
                busy_run      = 0;
                proto_err     = 0;
                last_done_cyc = cyc;
            end
            prev_done = bus.copy_done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.copy_start = 1'b1;
        @(negedge clk);
        bus.copy_start = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] leds, input int gap);
        exp_t e;
        e.leds = leds;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [15:0] img;
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        last_done_cyc  = 0;
        busy_run       = 0;
        proto_err      = 0;
        prev_done      = 1'b0;
        reset          = 1'b1;
        bus.copy_start = 1'b0;
        for (int i = 0; i < LED_COUNT; i++) mem[i] = 16'h0;

        // Reset values
        #12;
        check("rst_addr", 32'(bus.mem_din_addr), LED_ADDR);
        check("rst_re", 32'(bus.mem_din_re), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.copy_done), 0);
        check("rst_leds", 32'(bus.leds_out), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_start_busy", 32'(bus.busy), 0);

        // Alternating nonzero/zero words -> 0xAAAA
        for (int i = 0; i < LED_COUNT; i++)
            mem[i] = (i % 2 != 0) ? 16'h0000 : ((i % 4 == 0) ? 16'h0001 : 16'hFFFF);
        push_exp(16'hAAAA, 0);
        pulse_start();
        repeat (20) @(negedge clk);

        // Only the last word nonzero (MSB only) -> LSB of leds
        for (int i = 0; i < LED_COUNT; i++) mem[i] = 16'h0;
        mem[15] = 16'h8000;
        push_exp(16'h0001, 0);
        pulse_start();
        repeat (20) @(negedge clk);

        // copy_start held: two back-to-back passes 18 cycles apart
        for (int i = 0; i < LED_COUNT; i++) mem[i] = (i < 8) ? 16'h0100 : 16'h0000;
        push_exp(16'hFF00, 0);
        push_exp(16'hFF00, 18);
        @(negedge clk);
        bus.copy_start = 1'b1;
        repeat (36) @(negedge clk);
        bus.copy_start = 1'b0;
        repeat (6) @(negedge clk);

        // copy_start pulsed during READ and around DRAIN is ignored
        for (int i = 0; i < LED_COUNT; i++) mem[i] = (i == 3 || i == 12) ? 16'h0040 : 16'h0000;
        push_exp(16'h1008, 0);
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (9) @(negedge clk);
        bus.copy_start = 1'b1;
        @(negedge clk);
        bus.copy_start = 1'b0;
        repeat (25) @(negedge clk);

        // Asynchronous reset at READ cycle 5
        pulse_start();
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_leds", 32'(bus.leds_out), 0);
        check("midrst_addr", 32'(bus.mem_din_addr), LED_ADDR);
        check("midrst_re", 32'(bus.mem_din_re), 0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle_busy", 32'(bus.busy), 0);

        // Establish 0x1234, then watch an all-ones pass build up
        img = 16'h1234;
        for (int b = 0; b < LED_COUNT; b++) mem[LED_COUNT - 1 - b] = img[b] ? 16'h00FF : 16'h0000;
        push_exp(16'h1234, 0);
        pulse_start();
        repeat (20) @(negedge clk);
        for (int i = 0; i < LED_COUNT; i++) mem[i] = 16'hFFFF;
        push_exp(16'hFFFF, 0);
        pulse_start();
        repeat (5) @(negedge clk);
`ifdef LED_ATOMIC_UPDATE_EN
        check("leds_read5", 32'(bus.leds_out), 32'h1234);
`else
        check("leds_read5", 32'(bus.leds_out), 32'hF234);
`endif
        repeat (11) @(negedge clk);
`ifdef LED_ATOMIC_UPDATE_EN
        check("leds_drain", 32'(bus.leds_out), 32'h1234);
`else
        check("leds_drain", 32'(bus.leds_out), 32'hFFFE);
`endif
        repeat (6) @(negedge clk);

        check("pending_expectations", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
